// File: rtl/d_cmp_seq_if.sv
// +-----------------------------------------------------------------------+
// | Module   : d_cmp_seq_if                                               |
// | Desc     : Request/operand/result bundle for the D-stage comparator   |
// |            sequencer.                                                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

interface d_cmp_seq_if #(
   parameter int WIDTH = 32
);
   logic             D_Start;
   logic             D_Flush;
   logic [WIDTH-1:0] D_RD1;
   logic [WIDTH-1:0] D_RD2;
   logic             D_Busy;
   logic             D_Done;
   logic             D_Zero;
   logic             D_Flag;

   modport master (
      output D_Start, D_Flush, D_RD1, D_RD2,
      input  D_Busy, D_Done, D_Zero, D_Flag
   );

   modport slave (
      input  D_Start, D_Flush, D_RD1, D_RD2,
      output D_Busy, D_Done, D_Zero, D_Flag
   );
endinterface

`default_nettype wire

// File: rtl/d_cmp_seq.sv
// +-----------------------------------------------------------------------+
// | Module   : d_cmp_seq                                                  |
// | Desc     : Multi-cycle D-stage branch-condition sequencer: equality   |
// |            plus popcount-divisibility flag via slice scan + divider.  |
// |            Optional macro D_CMP_EARLY_EXIT_EN ends the scan once the   |
// |            remaining upper operand bits are all zero.                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module d_cmp_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  wire logic    clk,
   input  wire logic    reset,
   d_cmp_seq_if.slave   bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = $clog2(WIDTH) + 1;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
   localparam logic [IW-1:0] C_LAST  = IW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_rd1,   w_rd1_nxt;
   logic             r_eq,    w_eq_nxt;
   logic [CW-1:0]    r_cnt,   w_cnt_nxt;
   logic [CW-1:0]    r_rem,   w_rem_nxt;
   logic [IW-1:0]    r_idx,   w_idx_nxt;
   logic             r_zero,  w_zero_nxt;
   logic             r_flag,  w_flag_nxt;

   logic [SLICE-1:0] w_slice;
   logic [CW-1:0]    w_pop;
   logic [CW-1:0]    w_scan_cnt;
   logic             w_scan_end;

   always_comb begin
      w_slice = r_rd1[int'(r_idx)*SLICE +: SLICE];
      w_pop   = '0;
      for (int b = 0; b < SLICE; b++) begin
         w_pop = w_pop + CW'(w_slice[b]);
      end
      w_scan_cnt = r_cnt + w_pop;
   end

`ifdef D_CMP_EARLY_EXIT_EN
   logic w_upper_zero;
   // Nothing left to count once every bit above the current slice is clear.
   assign w_upper_zero = ((r_rd1 >> ((int'(r_idx) + 1) * SLICE)) == '0);
   assign w_scan_end   = (r_idx == C_LAST) || w_upper_zero;
`else
   assign w_scan_end   = (r_idx == C_LAST);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_rd1_nxt   = r_rd1;
      w_eq_nxt    = r_eq;
      w_cnt_nxt   = r_cnt;
      w_rem_nxt   = r_rem;
      w_idx_nxt   = r_idx;
      w_zero_nxt  = r_zero;
      w_flag_nxt  = r_flag;

      if (bus.D_Flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.D_Start) begin
                  w_rd1_nxt   = bus.D_RD1;
                  w_eq_nxt    = (bus.D_RD1 == bus.D_RD2);
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_state_nxt = S_SCAN;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_SCAN: begin
               w_cnt_nxt = w_scan_cnt;
               w_idx_nxt = r_idx + 1'b1;
               if (w_scan_end) begin
                  if (w_scan_cnt == '0) begin
                     w_flag_nxt  = 1'b0;
                     w_zero_nxt  = r_eq;
                     w_state_nxt = S_DONE;
                  end else begin
                     w_rem_nxt   = C_WIDTH - w_scan_cnt;
                     w_state_nxt = S_DIV;
                  end
               end
            end
            S_DIV: begin
               // Repeated subtraction; a zero remainder means cnt divides WIDTH-cnt.
               if (r_rem >= r_cnt) begin
                  w_rem_nxt = r_rem - r_cnt;
               end else begin
                  w_flag_nxt  = (r_rem == '0);
                  w_zero_nxt  = r_eq;
                  w_state_nxt = S_DONE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_rd1   <= '0;
         r_eq    <= 1'b0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_idx   <= '0;
         r_zero  <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rd1   <= w_rd1_nxt;
         r_eq    <= w_eq_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rem   <= w_rem_nxt;
         r_idx   <= w_idx_nxt;
         r_zero  <= w_zero_nxt;
         r_flag  <= w_flag_nxt;
      end
   end

   assign bus.D_Busy = (r_state == S_SCAN) || (r_state == S_DIV);
   assign bus.D_Done = (r_state == S_DONE);
   assign bus.D_Zero = r_zero;
   assign bus.D_Flag = r_flag;

endmodule

`default_nettype wire

// File: tb/tb_d_cmp_seq.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_d_cmp_seq                                               |
// | Desc     : Self-checking bench for d_cmp_seq against a popcount /     |
// |            divisibility reference model.                              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_d_cmp_seq;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 4;
   localparam int NSLICE = WIDTH / SLICE;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic m_zero = 1'b0;
   logic m_flag = 1'b0;

   d_cmp_seq_if #(.WIDTH(WIDTH)) bus ();

   d_cmp_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int scan_len(input logic [WIDTH-1:0] rd1);
      int s_len;
      s_len = NSLICE;
`ifdef D_CMP_EARLY_EXIT_EN
      s_len = 1;
      for (int s = 0; s < NSLICE; s++) begin
         if (((rd1 >> (s * SLICE)) & ((1 << SLICE) - 1)) != 0) s_len = s + 1;
      end
`endif
      return s_len;
   endfunction

   // Expected latency and flag straight from the arithmetic definition.
   function automatic int model(input logic [WIDTH-1:0] rd1, output logic flag);
      int cnt;
      int lat;
      cnt  = $countones(rd1);
      flag = 1'b0;
      lat  = scan_len(rd1);
      if (cnt != 0) begin
         flag = (((WIDTH - cnt) % cnt) == 0);
         lat  = lat + (WIDTH - cnt) / cnt + 1;
      end
      return lat;
   endfunction

   task automatic wait_done(input bit poke, output int n, output int busy_n);
      n      = 0;
      busy_n = 0;
      while (bus.D_Done !== 1'b1 && n <= 100) begin
         if (bus.D_Busy === 1'b1) busy_n++;
         bus.D_Start = poke && (bus.D_Busy === 1'b1) && ($urandom_range(3) == 0);
         @(posedge clk); #1;
         bus.D_Start = 1'b0;
         n++;
      end
   endtask

   task automatic run_req(input logic [WIDTH-1:0] rd1, input logic [WIDTH-1:0] rd2, input bit poke);
      logic f;
      int   lat, n, busy_n;
      lat = model(rd1, f);
      @(negedge clk);
      bus.D_RD1   = rd1;
      bus.D_RD2   = rd2;
      bus.D_Start = 1'b1;
      @(posedge clk); #1;
      bus.D_Start = 1'b0;
      bus.D_RD1   = $urandom;
      bus.D_RD2   = $urandom;
      check("hold_zero", bus.D_Zero, m_zero);
      check("hold_flag", bus.D_Flag, m_flag);
      wait_done(poke, n, busy_n);
      m_zero = (rd1 == rd2);
      m_flag = f;
      check("latency", n, lat);
      check("busy_cycles", busy_n, lat);
      check("done", bus.D_Done, 1);
      check("zero", bus.D_Zero, m_zero);
      check("flag", bus.D_Flag, m_flag);
      @(posedge clk); #1;
      check("done_pulse", bus.D_Done, 0);
   endtask

   initial begin
      logic             f;
      logic [WIDTH-1:0] a, b;
      int               n, busy_n, lat, dones;

      bus.D_Start = 1'b0;
      bus.D_Flush = 1'b0;
      bus.D_RD1   = '0;
      bus.D_RD2   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus.D_Busy, 0);
      check("rst_done", bus.D_Done, 0);
      check("rst_zero", bus.D_Zero, 0);
      check("rst_flag", bus.D_Flag, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", bus.D_Busy, 0);

      run_req(32'h0000_000F, 32'h0000_000F, 1'b1);
      run_req(32'h0000_0007, 32'h0000_0006, 1'b1);
      run_req(32'h0000_0000, 32'h0000_0000, 1'b0);
      run_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      run_req(32'h0000_000F, 32'h0000_000F, 1'b0);

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      bus.D_RD1   = 32'h8000_0000;
      bus.D_RD2   = 32'h8000_0000;
      bus.D_Start = 1'b1;
      @(posedge clk); #1;
      bus.D_Start = 1'b0;
      @(posedge clk); #2;
      check("midscan_busy", bus.D_Busy, 1);
      reset = 1'b0;
      #1;
      check("arst_busy", bus.D_Busy, 0);
      check("arst_done", bus.D_Done, 0);
      check("arst_zero", bus.D_Zero, 0);
      check("arst_flag", bus.D_Flag, 0);
      m_zero = 1'b0;
      m_flag = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_busy", bus.D_Busy, 0);
      check("post_rst_done", bus.D_Done, 0);

      // Flush on the third divider edge; previous results must survive.
      run_req(32'h0000_0007, 32'h0000_0006, 1'b0);
      @(negedge clk);
      bus.D_RD1   = 32'h0000_0001;
      bus.D_RD2   = 32'h0000_0001;
      bus.D_Start = 1'b1;
      @(posedge clk); #1;
      bus.D_Start = 1'b0;
      repeat (scan_len(32'h0000_0001) + 2) @(posedge clk);
      #1;
      check("pre_flush_busy", bus.D_Busy, 1);
      bus.D_Flush = 1'b1;
      @(posedge clk); #1;
      bus.D_Flush = 1'b0;
      check("flush_busy", bus.D_Busy, 0);
      check("flush_done", bus.D_Done, 0);
      check("flush_zero", bus.D_Zero, m_zero);
      check("flush_flag", bus.D_Flag, m_flag);
      dones = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.D_Done === 1'b1 || bus.D_Busy === 1'b1) dones++;
      end
      check("flush_quiet", dones, 0);

      // Flush beats a simultaneous start in IDLE.
      @(negedge clk);
      bus.D_RD1   = 32'h0000_000F;
      bus.D_RD2   = 32'h0000_000F;
      bus.D_Start = 1'b1;
      bus.D_Flush = 1'b1;
      @(posedge clk); #1;
      bus.D_Start = 1'b0;
      bus.D_Flush = 1'b0;
      check("flush_start_busy", bus.D_Busy, 0);
      @(posedge clk); #1;
      check("flush_start_done", bus.D_Done, 0);

      // Back-to-back: start held through DONE, worst-case first request.
      a   = 32'h8000_0000;
      b   = 32'h0000_00F0;
      lat = model(a, f);
      @(negedge clk);
      bus.D_RD1   = a;
      bus.D_RD2   = a;
      bus.D_Start = 1'b1;
      @(posedge clk); #1;
      bus.D_RD1 = b;
      bus.D_RD2 = 32'h1234_5678;
      n = 0;
      while (bus.D_Done !== 1'b1 && n <= 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_lat_a", n, lat);
      check("b2b_lat_a_const", n, 40);
      m_zero = 1'b1;
      m_flag = f;
      check("b2b_zero_a", bus.D_Zero, m_zero);
      check("b2b_flag_a", bus.D_Flag, m_flag);
      @(posedge clk); #1;
      bus.D_Start = 1'b0;
      check("b2b_accept", bus.D_Busy, 1);
      check("b2b_hold_zero", bus.D_Zero, m_zero);
      lat = model(b, f);
      wait_done(1'b0, n, busy_n);
      m_zero = 1'b0;
      m_flag = f;
      check("b2b_lat_b", n, lat);
      check("b2b_zero_b", bus.D_Zero, m_zero);
      check("b2b_flag_b", bus.D_Flag, m_flag);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(3))
            0:       a = $urandom;
            1:       a = 32'h1 << $urandom_range(31);
            2:       a = $urandom & $urandom & $urandom;
            default: a = 32'hFFFF_FFFF >> $urandom_range(31);
         endcase
         b = ($urandom_range(1) == 1) ? a : (a ^ (32'h1 << $urandom_range(31)));
         repeat ($urandom_range(3)) @(posedge clk);
         run_req(a, b, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
